ov7670_stream_generator: RTL and testbench

Synthesizable OV7670 camera emulator. It drives the transmit side of the parallel camera bus (VSYNC, HREF, PCLK, D[7:0]) that interface_OV7670 receives. It fetches RGB565 pixels from an external source through a line/column address and serializes each pixel as two bytes. It is used for hardware-in-loop testing of the capture path without a physical sensor.

---
 rtl/ov7670_pkg.sv | 28 ++
 rtl/ov7670_pclk_div.sv | 49 ++++
 rtl/ov7670_stream_generator.sv | 217 +++++++++++++++++++++
 tb/tb_ov7670_stream_generator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared definitions for the OV7670 parallel-bus stream generator and the
// matching receiver (interface_OV7670):
//   state_t         FSM state encoding; the values are also the db_estado codes
//   OV_LINES ..     default frame geometry and address widths
//   max_int()       small elaboration-time helper
// ---------------------------------------------------------------------------
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FRONT = 3'd1,
        ST_LINE  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIM   = 3'd4
    } state_t;

    localparam int OV_LINES    = 140;
    localparam int OV_COLUMNS  = 320;
    localparam int OV_S_LINE   = 8;
    localparam int OV_S_COLUMN = 9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov7670_pclk_div.sv
// ---------------------------------------------------------------------------
// ov7670_pclk_div
// PCLK generator. While enabled, a divider counts 0..PCLK_HALF-1 and toggles
// PCLK at the terminal count; while disabled, divider and PCLK sit at 0 so the
// first period after enable always starts from a known phase.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   enable        run the divider (low in IDLE)
//   pclk          registered pixel clock
//   fall_tick     high on the clock edge that registers PCLK 1->0
//   rise_tick     high on the clock edge that registers PCLK 0->1
// ---------------------------------------------------------------------------
module ov7670_pclk_div #(
    parameter int PCLK_HALF = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic pclk,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CNT_W = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PCLK_HALF - 1);

    logic [CNT_W-1:0] cnt;
    logic             terminal;

    assign terminal  = (cnt == CNT_LAST);
    assign fall_tick = enable & terminal &  pclk;
    assign rise_tick = enable & terminal & ~pclk;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            pclk <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            pclk <= 1'b0;
        end else if (terminal) begin
            cnt  <= '0;
            pclk <= ~pclk;
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ov7670_stream_generator.sv
// ---------------------------------------------------------------------------
// ov7670_stream_generator
// OV7670 camera emulator: drives VSYNC/HREF/PCLK/D of the parallel camera
// bus, fetching RGB565 pixels by (linha, coluna) and sending each pixel as
// high byte then low byte. All bus outputs change only on the PCLK falling
// edge, leaving PCLK_HALF clocks of setup and hold around each rising edge.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   iniciar        level; starts one frame when seen in IDLE
//   pixel_in       RGB565 pixel at (linha, coluna)
//   linha, coluna  address of the next pixel to send
//   VSYNC          1 = idle / between frames
//   HREF           1 while line bytes are valid
//   PCLK           pixel clock, receiver samples on rising edge
//   D              byte data
//   pronto         one-clock pulse at end of frame
//   db_estado      current state code
// ---------------------------------------------------------------------------
module ov7670_stream_generator
    import ov7670_pkg::*;
#(
    parameter int LINES       = OV_LINES,
    parameter int COLUMNS     = OV_COLUMNS,
    parameter int S_LINE      = OV_S_LINE,
    parameter int S_COLUMN    = OV_S_COLUMN,
    parameter int PCLK_HALF   = 2,
    parameter int FRONT_PCLKS = 5,
    parameter int GAP_PCLKS   = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [15:0]         pixel_in,
    output logic [S_LINE-1:0]   linha,
    output logic [S_COLUMN-1:0] coluna,
    output logic                VSYNC,
    output logic                HREF,
    output logic                PCLK,
    output logic [7:0]          D,
    output logic                pronto,
    output logic [3:0]          db_estado
);

    localparam int WAIT_MAX = max_int(FRONT_PCLKS, GAP_PCLKS);
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0]   FRONT_LAST = WAIT_W'(FRONT_PCLKS - 1);
    localparam logic [WAIT_W-1:0]   GAP_LAST   = WAIT_W'(GAP_PCLKS - 1);
    localparam logic [S_LINE-1:0]   LINE_LAST  = S_LINE'(LINES - 1);
    localparam logic [S_COLUMN-1:0] COL_LAST   = S_COLUMN'(COLUMNS - 1);

    state_t                state, state_next;
    logic                  vsync_next, href_next, pronto_next;
    logic [7:0]            d_next;
    logic [S_LINE-1:0]     linha_next;
    logic [S_COLUMN-1:0]   coluna_next;
    logic [WAIT_W-1:0]     espera, espera_next;
    logic [15:0]           pix, pix_next;
    // fase=1: the high byte is on D, the low byte is due next
    logic                  fase, fase_next;
    // low byte of the last column has been launched; next tick ends the line
    logic                  fim_linha, fim_linha_next;
    // the line now in GAP was the last one of the frame
    logic                  fim_quadro, fim_quadro_next;
    logic                  fall_tick;
    logic                  rise_tick_unused;

    ov7670_pclk_div #(
        .PCLK_HALF (PCLK_HALF)
    ) u_pclk_div (
        .clock     (clock),
        .reset     (reset),
        .enable    (state != ST_IDLE),
        .pclk      (PCLK),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick_unused)
    );

    assign db_estado = {1'b0, state};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            VSYNC      <= 1'b1;
            HREF       <= 1'b0;
            D          <= '0;
            pronto     <= 1'b0;
            linha      <= '0;
            coluna     <= '0;
            espera     <= '0;
            pix        <= '0;
            fase       <= 1'b0;
            fim_linha  <= 1'b0;
            fim_quadro <= 1'b0;
        end else begin
            state      <= state_next;
            VSYNC      <= vsync_next;
            HREF       <= href_next;
            D          <= d_next;
            pronto     <= pronto_next;
            linha      <= linha_next;
            coluna     <= coluna_next;
            espera     <= espera_next;
            pix        <= pix_next;
            fase       <= fase_next;
            fim_linha  <= fim_linha_next;
            fim_quadro <= fim_quadro_next;
        end
    end

    always_comb begin
        state_next      = state;
        vsync_next      = VSYNC;
        href_next       = HREF;
        d_next          = D;
        pronto_next     = 1'b0;
        linha_next      = linha;
        coluna_next     = coluna;
        espera_next     = espera;
        pix_next        = pix;
        fase_next       = fase;
        fim_linha_next  = fim_linha;
        fim_quadro_next = fim_quadro;

        case (state)
            ST_IDLE: begin
                vsync_next = 1'b1;
                if (iniciar) begin
                    state_next  = ST_FRONT;
                    vsync_next  = 1'b0;
                    espera_next = '0;
                end
            end

            ST_FRONT: begin
                if (fall_tick) begin
                    if (espera == FRONT_LAST) begin
                        state_next  = ST_LINE;
                        espera_next = '0;
                        href_next   = 1'b1;
                        d_next      = pixel_in[15:8];
                        pix_next    = pixel_in;
                        fase_next   = 1'b1;
                    end else begin
                        espera_next = espera + WAIT_W'(1);
                    end
                end
            end

            ST_LINE: begin
                if (fall_tick) begin
                    if (fase) begin
                        // Low byte comes from the captured pixel, so moving
                        // the address on this tick is safe.
                        d_next    = pix[7:0];
                        fase_next = 1'b0;
                        if (coluna == COL_LAST) begin
                            fim_linha_next = 1'b1;
                        end else begin
                            coluna_next = coluna + S_COLUMN'(1);
                        end
                    end else if (fim_linha) begin
                        // Address the first pixel of the next line now so it
                        // has the whole gap to settle.
                        state_next     = ST_GAP;
                        href_next      = 1'b0;
                        d_next         = '0;
                        fim_linha_next = 1'b0;
                        espera_next    = '0;
                        if (linha == LINE_LAST) begin
                            fim_quadro_next = 1'b1;
                        end else begin
                            linha_next  = linha + S_LINE'(1);
                            coluna_next = '0;
                        end
                    end else begin
                        d_next    = pixel_in[15:8];
                        pix_next  = pixel_in;
                        fase_next = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (fall_tick) begin
                    if (espera == GAP_LAST) begin
                        espera_next = '0;
                        if (fim_quadro) begin
                            state_next      = ST_FIM;
                            vsync_next      = 1'b1;
                            pronto_next     = 1'b1;
                            fim_quadro_next = 1'b0;
                        end else begin
                            state_next = ST_LINE;
                            href_next  = 1'b1;
                            d_next     = pixel_in[15:8];
                            pix_next   = pixel_in;
                            fase_next  = 1'b1;
                        end
                    end else begin
                        espera_next = espera + WAIT_W'(1);
                    end
                end
            end

            ST_FIM: begin
                state_next  = ST_IDLE;
                linha_next  = '0;
                coluna_next = '0;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ov7670_stream_generator.sv
module tb_ov7670_stream_generator;

    localparam int LINES   = 2;
    localparam int COLUMNS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [15:0] pixel_in;
    logic [7:0]  linha;
    logic [8:0]  coluna;
    logic        VSYNC, HREF, PCLK, pronto;
    logic [7:0]  D;
    logic [3:0]  db_estado;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb[$];
    int  href_pulses = 0;
    int  pronto_cnt  = 0;
    int  line_bytes  = 0;
    int  front_cnt   = 0;
    bit  in_front    = 0;
    logic pclk_prev = 0, href_prev = 0, vsync_prev = 1, pronto_prev = 0;
    logic [7:0] d_prev = 0;

    always #5 clock = ~clock;

    assign pixel_in = {linha, 8'(coluna)};

    ov7670_stream_generator #(
        .LINES       (LINES),
        .COLUMNS     (COLUMNS),
        .S_LINE      (8),
        .S_COLUMN    (9),
        .PCLK_HALF   (2),
        .FRONT_PCLKS (5),
        .GAP_PCLKS   (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .pixel_in  (pixel_in),
        .linha     (linha),
        .coluna    (coluna),
        .VSYNC     (VSYNC),
        .HREF      (HREF),
        .PCLK      (PCLK),
        .D         (D),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int l = 0; l < LINES; l++)
            for (int c = 0; c < COLUMNS; c++) begin
                sb.push_back(8'(l));
                sb.push_back(8'(c));
            end
    endtask

    // {VSYNC,HREF,PCLK,D,pronto,db_estado} in reset/idle: 1,0,0,00,0,0
    function automatic logic [31:0] bus_vec();
        return {16'd0, VSYNC, HREF, PCLK, D, pronto, db_estado};
    endfunction
    localparam logic [31:0] IDLE_VEC = {16'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0};

    task automatic start_frame();
        @(posedge clock); #1 iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
    endtask

    task automatic wait_pronto(input string name);
        bit seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clock);
            if (pronto) seen = 1;
        end
        check({name, "_pronto_seen"}, 32'(seen), 1);
    endtask

    // Monitor: samples on the falling system clock, well away from any edge.
    always @(negedge clock) begin
        if (reset) begin
            pclk_prev = 0; href_prev = 0; vsync_prev = 1; pronto_prev = 0;
            d_prev = 0; line_bytes = 0; in_front = 0; front_cnt = 0;
        end else begin
            if (PCLK && !pclk_prev) begin
                if (HREF) begin
                    if (sb.size() == 0) check("sb_underflow", 1, 0);
                    else check("byte", 32'(D), 32'(sb.pop_front()));
                    line_bytes++;
                end else if (in_front) begin
                    front_cnt++;
                end
            end
            if (!VSYNC && vsync_prev) begin
                in_front = 1; front_cnt = 0;
            end
            if (HREF && !href_prev) begin
                href_pulses++;
                if (in_front) begin
                    check("front_pclks", 32'(front_cnt), 5);
                    in_front = 0;
                end
                line_bytes = 0;
            end
            if (!HREF && href_prev) check("line_bytes", 32'(line_bytes), 2 * COLUMNS);
            if (D !== d_prev || HREF !== href_prev)
                check("launch_on_pclk_fall", {30'd0, pclk_prev, PCLK}, 32'b10);
            if (pronto) begin
                pronto_cnt++;
                check("pronto_vsync", 32'(VSYNC), 1);
                check("pronto_single", 32'(pronto_prev), 0);
            end
            pclk_prev = PCLK; href_prev = HREF; vsync_prev = VSYNC;
            pronto_prev = pronto; d_prev = D;
        end
    end

    initial begin
        int h0, p0;
        bit hit;
        reset = 1'b1;
        iniciar = 1'b0;
        repeat (3) @(posedge clock);
        #1 check("reset_bus", bus_vec(), IDLE_VEC);
        check("reset_addr", {15'd0, linha, coluna}, 0);
        reset = 1'b0;

        // Idle with iniciar low
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("idle_bus", bus_vec(), IDLE_VEC);
        end

        // One full frame
        push_frame();
        h0 = href_pulses;
        start_frame();
        wait_pronto("frame1");
        repeat (3) @(negedge clock);
        #1 check("frame1_sb_empty", 32'(sb.size()), 0);
        check("frame1_href_pulses", 32'(href_pulses - h0), LINES);
        check("frame1_idle_after", bus_vec(), IDLE_VEC);
        check("frame1_addr_cleared", {15'd0, linha, coluna}, 0);

        // Reset in the middle of line 1, column 2
        push_frame();
        start_frame();
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clock);
            if (HREF && linha == 8'd1 && coluna == 9'd2) hit = 1;
        end
        check("midreset_reached", 32'(hit), 1);
        #1 reset = 1'b1;
        #1 check("midreset_bus", bus_vec(), IDLE_VEC);
        check("midreset_addr", {15'd0, linha, coluna}, 0);
        repeat (2) @(posedge clock);
        sb.delete();
        #1 reset = 1'b0;

        // Fresh frame after the interrupted one
        push_frame();
        start_frame();
        wait_pronto("frame_after_reset");
        repeat (3) @(negedge clock);
        #1 check("after_reset_sb_empty", 32'(sb.size()), 0);

        // Three back-to-back frames with iniciar held high
        push_frame(); push_frame(); push_frame();
        h0 = href_pulses;
        p0 = pronto_cnt;
        @(posedge clock); #1 iniciar = 1'b1;
        for (int i = 0; i < 6000 && (pronto_cnt - p0) < 3; i++) begin
            @(negedge clock);
            #1;
        end
        iniciar = 1'b0;
        check("b2b_pronto_count", 32'(pronto_cnt - p0), 3);
        repeat (20) @(negedge clock);
        #1 check("b2b_href_pulses", 32'(href_pulses - h0), 3 * LINES);
        check("b2b_sb_empty", 32'(sb.size()), 0);
        check("b2b_idle_after", bus_vec(), IDLE_VEC);
        check("b2b_no_extra_frame", 32'(pronto_cnt - p0), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
